spi_lcd_rx: RTL and testbench
=============================

# spi_lcd_rx

Receive-side decoder for the 4-wire LCD SPI link (MOSI, CS, DC, SCLK) driven by the display controller. It deserialises bytes and tracks the column/page window commands. It also converts RAMWR data into addressed RGB565 pixel writes. It is used as the display model in system benches and as an on-chip frame-capture monitor.

## Interface
- WIDTH, 240, panel columns; X range 0..WIDTH-1
- HEIGHT, 320, panel rows; Y range 0..HEIGHT-1
- i_clk  in  1  system clock, also the SPI bit clock; MOSI/DC are sampled on the rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_cs  in  1  chip select, active low
- i_dc  in  1  0 = command byte, 1 = data byte; sampled with bit 0 of each byte
- i_mosi  in  1  serial data, MSB first
- o_byte  out  8  last received byte
- o_byte_dc  out  1  DC value captured with o_byte
- o_byte_valid  out  1  one-cycle pulse, new byte on o_byte
- o_cmd  out  8  current command opcode
- o_pix_valid  out  1  one-cycle pulse, pixel write
- o_pix_x  out  9  pixel column
- o_pix_y  out  9  pixel row
- o_pix_data  out  16  RGB565 pixel, high byte first on the wire
- o_frame_done  out  1  one-cycle pulse when the last pixel of the window is written
- o_err  out  1  sticky protocol-error flag

## Operation
- **Reset values.** All outputs are 0 except o_cmd = 8'h00. The window is XS=0, XE=WIDTH-1, YS=0, YE=HEIGHT-1. The bit counter is 0 and the FSM is in IDLE.
- **Byte assembly.** While i_cs=0, each rising edge shifts i_mosi into an 8-bit shift register and increments a 3-bit counter. On the 8th bit the byte and i_dc are registered and o_byte_valid pulses.
- **CS high mid-byte.**
  - The partial byte is discarded and the counter is cleared.
  - A partial pixel (high byte only) is discarded.
  - o_err is set.
  - Command context is retained.
- **Command FSM.** States are IDLE, CASET, PASET, RAMWR, OTHER. Any byte with dc=0 loads o_cmd and selects the state:
  - 0x2A → CASET
  - 0x2B → PASET
  - 0x2C → RAMWR
  - anything else → OTHER
- **Parameter rules.**
  - CASET/PASET take 4 data bytes: start hi, start lo, end hi, end lo. The 16-bit values are assembled in staging registers.
  - After the 4th byte the window is committed only if start ≤ end and end < WIDTH (CASET) or end < HEIGHT (PASET). Otherwise the window is unchanged and o_err is set.
  - Extra data bytes beyond 4 are ignored.
  - A new command before the 4th byte abandons the update; the window is unchanged and no error is raised.
- **RAMWR entry.** Entering RAMWR sets X=XS, Y=YS and clears the pixel phase.
- **RAMWR pixel assembly.** Data bytes alternate high/low. Each low byte emits one pixel at (X,Y).
- **RAMWR address advance.** After each pixel:
  - X advances.
  - At X=XE, X wraps to XS and Y advances.
  - At X=XE and Y=YE, both wrap to the start, o_frame_done pulses together with that pixel's o_pix_valid, and writing continues.
- **OTHER/IDLE.** Data bytes only produce o_byte_valid.

## Timing
- o_byte_valid goes high in the cycle after the edge that samples bit 0; bytes may be back-to-back every 8 cycles.
- o_pix_valid and o_frame_done go high one cycle after the o_byte_valid of the low byte.
- o_pix_x, o_pix_y and o_pix_data are stable while o_pix_valid is high.
- A window commit is visible one cycle after the 4th parameter's o_byte_valid.
- i_cs rising on the same edge as bit 0 counts as a completed byte.
- o_err clears only on reset.
- Reset mid-operation returns everything to the reset values immediately.

## Configuration
- **SPI_LCD_RX_ERR_EN defined:** o_err is driven by the rules above.
- **SPI_LCD_RX_ERR_EN undefined:**
  - o_err is tied to 0 and no error logic is synthesised.
  - Invalid CASET/PASET parameter sets are still rejected silently.

## Structure
- Package spi_lcd_pkg holds:
  - the command constants CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C
  - the FSM state enum
  - the coordinate width constant (9)
- Sub-module spi_byte_rx holds the shift register, bit counter and byte-valid generation. The top holds the command FSM, window registers and address counters.

## Test plan
- Send cmd 0x2A then data 00 0A 00 0C; send 0x2B then data 00 05 00 05; send 0x2C then 6 bytes F8 00 07 E0 00 1F → pixels (10,5)=F800, (11,5)=07E0, (12,5)=001F, with o_frame_done on the third pixel.
- RAMWR with the default window, 240×320×2 bytes → 76800 o_pix_valid pulses, the last at (239,319) with o_frame_done; the next pixel lands at (0,0).
- Send CASET params 00 F0 00 F0 (240) → window unchanged, o_err=1; a following RAMWR pixel lands at (0,0).
- Drop i_cs high after 4 bits of a RAMWR high byte, then resume with bytes 12 34 → single pixel 1234 at the current address, o_err=1.
- Send CASET with only 2 params, then 0x2C plus 2 bytes → pixel at the old XS, o_err=0.
- Pulse i_rst low during RAMWR → outputs 0, window restored to defaults, the next byte decodes cleanly.

Source files
------------

// File: rtl/spi_lcd_pkg.sv
// Shared constants and state encoding for the LCD SPI receive decoder.
package spi_lcd_pkg;

    localparam int COORD_W = 9;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CASET = 3'd1,
        ST_PASET = 3'd2,
        ST_RAMWR = 3'd3,
        ST_OTHER = 3'd4
    } lcd_state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Serial-to-byte deserialiser: MSB-first shift, DC captured with the last bit,
// abort pulse when chip select drops a byte part-way through.
module spi_byte_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       dc,
    input  logic       mosi,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       byte_valid,
    output logic       abort
);

    logic [6:0] shift;
    logic [2:0] bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift      <= '0;
            bit_cnt    <= '0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
            byte_valid <= 1'b0;
            abort      <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            abort      <= 1'b0;
            if (!cs) begin
                shift   <= {shift[5:0], mosi};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_data  <= {shift, mosi};
                    byte_dc    <= dc;
                    byte_valid <= 1'b1;
                end
            end else if (bit_cnt != 3'd0) begin
                // bit 0 sampled with cs still low leaves the counter at 0, so no abort
                bit_cnt <= '0;
                abort   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_lcd_rx.sv
// LCD SPI receive decoder: command FSM, CASET/PASET window, RAMWR pixel addressing.
// Define SPI_LCD_RX_ERR_EN to build the sticky protocol-error flag o_err.
//
// state    | meaning
// ST_IDLE  | no command seen since reset
// ST_CASET | collecting column start/end parameters
// ST_PASET | collecting page start/end parameters
// ST_RAMWR | data bytes form RGB565 pixels at the running address
// ST_OTHER | unsupported command, data bytes only echoed
module spi_lcd_rx
    import spi_lcd_pkg::*;
#(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cs,
    input  logic               i_dc,
    input  logic               i_mosi,
    output logic [7:0]         o_byte,
    output logic               o_byte_dc,
    output logic               o_byte_valid,
    output logic [7:0]         o_cmd,
    output logic               o_pix_valid,
    output logic [COORD_W-1:0] o_pix_x,
    output logic [COORD_W-1:0] o_pix_y,
    output logic [15:0]        o_pix_data,
    output logic               o_frame_done,
    output logic               o_err
);

    localparam logic [15:0]        WIDTH_L  = 16'(WIDTH);
    localparam logic [15:0]        HEIGHT_L = 16'(HEIGHT);
    localparam logic [COORD_W-1:0] XE_RST   = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] YE_RST   = COORD_W'(HEIGHT - 1);

    logic               abort;
    lcd_state_t         state;
    logic [2:0]         param_cnt;
    logic [15:0]        stage_start;
    logic [7:0]         stage_end_hi;
    logic [15:0]        param_end;
    logic [15:0]        param_limit;
    logic               param_ok;
    logic [COORD_W-1:0] xs, xe, ys, ye, x, y;
    logic               phase;
    logic [7:0]         pix_hi;

    spi_byte_rx u_byte_rx (
        .clk        (i_clk),
        .rst_n      (i_rst),
        .cs         (i_cs),
        .dc         (i_dc),
        .mosi       (i_mosi),
        .byte_data  (o_byte),
        .byte_dc    (o_byte_dc),
        .byte_valid (o_byte_valid),
        .abort      (abort)
    );

    assign param_end   = {stage_end_hi, o_byte};
    assign param_limit = (state == ST_CASET) ? WIDTH_L : HEIGHT_L;
    assign param_ok    = (stage_start <= param_end) && (param_end < param_limit);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= ST_IDLE;
            o_cmd        <= '0;
            param_cnt    <= '0;
            stage_start  <= '0;
            stage_end_hi <= '0;
            xs           <= '0;
            xe           <= XE_RST;
            ys           <= '0;
            ye           <= YE_RST;
            x            <= '0;
            y            <= '0;
            phase        <= 1'b0;
            pix_hi       <= '0;
            o_pix_valid  <= 1'b0;
            o_pix_x      <= '0;
            o_pix_y      <= '0;
            o_pix_data   <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_pix_valid  <= 1'b0;
            o_frame_done <= 1'b0;
            if (o_byte_valid && !o_byte_dc) begin
                o_cmd     <= o_byte;
                param_cnt <= '0;
                phase     <= 1'b0;
                case (o_byte)
                    CMD_CASET: state <= ST_CASET;
                    CMD_PASET: state <= ST_PASET;
                    CMD_RAMWR: begin
                        state <= ST_RAMWR;
                        x     <= xs;
                        y     <= ys;
                    end
                    default:   state <= ST_OTHER;
                endcase
            end else if (o_byte_valid) begin
                case (state)
                    ST_CASET, ST_PASET: begin
                        if (param_cnt != 3'd4) begin
                            param_cnt <= param_cnt + 3'd1;
                            case (param_cnt)
                                3'd0: stage_start[15:8] <= o_byte;
                                3'd1: stage_start[7:0]  <= o_byte;
                                3'd2: stage_end_hi      <= o_byte;
                                default: begin
                                    if (param_ok && state == ST_CASET) begin
                                        xs <= stage_start[COORD_W-1:0];
                                        xe <= param_end[COORD_W-1:0];
                                    end else if (param_ok) begin
                                        ys <= stage_start[COORD_W-1:0];
                                        ye <= param_end[COORD_W-1:0];
                                    end
                                end
                            endcase
                        end
                    end
                    ST_RAMWR: begin
                        if (!phase) begin
                            pix_hi <= o_byte;
                            phase  <= 1'b1;
                        end else begin
                            phase       <= 1'b0;
                            o_pix_valid <= 1'b1;
                            o_pix_x     <= x;
                            o_pix_y     <= y;
                            o_pix_data  <= {pix_hi, o_byte};
                            if (x == xe) begin
                                x <= xs;
                                if (y == ye) begin
                                    y            <= ys;
                                    o_frame_done <= 1'b1;
                                end else begin
                                    y <= y + COORD_W'(1);
                                end
                            end else begin
                                x <= x + COORD_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
            // a truncated byte also throws away any pending high byte
            if (abort) phase <= 1'b0;
        end
    end

`ifdef SPI_LCD_RX_ERR_EN
    logic param_fail;
    logic err_q;

    assign param_fail = o_byte_valid && o_byte_dc && param_cnt == 3'd3 && !param_ok &&
                        (state == ST_CASET || state == ST_PASET);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                   err_q <= 1'b0;
        else if (abort || param_fail) err_q <= 1'b1;
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Directed bench for spi_lcd_rx: table of bytes with expected echo/pixel results,
// then hand-written sequences for window limits, aborts and reset.
module tb_spi_lcd_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1;
    logic        dc = 1'b0;
    logic        mosi = 1'b0;
    logic [7:0]  o_byte;
    logic        o_byte_dc;
    logic        o_byte_valid;
    logic [7:0]  o_cmd;
    logic        o_pix_valid;
    logic [8:0]  o_pix_x;
    logic [8:0]  o_pix_y;
    logic [15:0] o_pix_data;
    logic        o_frame_done;
    logic        o_err;

`ifdef SPI_LCD_RX_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    spi_lcd_rx dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_cs         (cs),
        .i_dc         (dc),
        .i_mosi       (mosi),
        .o_byte       (o_byte),
        .o_byte_dc    (o_byte_dc),
        .o_byte_valid (o_byte_valid),
        .o_cmd        (o_cmd),
        .o_pix_valid  (o_pix_valid),
        .o_pix_x      (o_pix_x),
        .o_pix_y      (o_pix_y),
        .o_pix_data   (o_pix_data),
        .o_frame_done (o_frame_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
        logic        fd;
    } pix_t;

    typedef struct {
        logic        dc;
        logic [7:0]  data;
        logic [7:0]  exp_cmd;
        logic        pix;
        logic [8:0]  px;
        logic [8:0]  py;
        logic [15:0] pd;
        logic        fd;
    } vec_t;

    pix_t       pix_q[$];
    logic [7:0] last_byte = '0;
    logic       last_dc = 1'b0;
    int         byte_cnt = 0;
    int         fd_cnt = 0;
    int         n_pass = 0;
    int         n_total = 0;

    always @(negedge clk) begin
        if (o_pix_valid) pix_q.push_back('{o_pix_x, o_pix_y, o_pix_data, o_frame_done});
        if (o_frame_done) fd_cnt++;
        if (o_byte_valid) begin
            last_byte = o_byte;
            last_dc   = o_byte_dc;
            byte_cnt++;
        end
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic check_pix(input string name, input int idx, input logic [8:0] ex,
                             input logic [8:0] ey, input logic [15:0] ed, input logic efd);
        pix_t want;
        want = '{ex, ey, ed, efd};
        if (idx >= pix_q.size()) check({name, " missing"}, 40'(pix_q.size()), 40'(idx + 1));
        else check(name, 40'(pix_q[idx]), 40'(want));
    endtask

    task automatic send_byte(input logic bdc, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            cs   = 1'b0;
            dc   = bdc;
            mosi = b[i];
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            cs   = 1'b0;
            dc   = 1'b1;
            mosi = b[i];
        end
        @(negedge clk);
        cs = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic gap();
        @(negedge clk);
        cs = 1'b1;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic send_window(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
        send_byte(1'b0, cmd);
        send_byte(1'b1, s[15:8]);
        send_byte(1'b1, s[7:0]);
        send_byte(1'b1, e[15:8]);
        send_byte(1'b1, e[7:0]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cs    = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pix_q.delete();
        fd_cnt = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[15];

    initial begin
        int n;
        int base;
        vecs[0]  = '{1'b0, 8'h2A, 8'h2A, 1'b0, 9'd0,  9'd0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 8'h00, 8'h2A, 1'b0, 9'd0,  9'd0, 16'h0000, 1'b0};
        vecs[2]  = '{1'b1, 8'h0A, 8'h2A, 1'b0, 9'd0,  9'd0, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 8'h00, 8'h2A, 1'b0, 9'd0,  9'd0, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 8'h0C, 8'h2A, 1'b0, 9'd0,  9'd0, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 8'h2B, 8'h2B, 1'b0, 9'd0,  9'd0, 16'h0000, 1'b0};
        vecs[6]  = '{1'b1, 8'h00, 8'h2B, 1'b0, 9'd0,  9'd0, 16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 8'h05, 8'h2B, 1'b0, 9'd0,  9'd0, 16'h0000, 1'b0};
        vecs[8]  = '{1'b1, 8'h00, 8'h2B, 1'b0, 9'd0,  9'd0, 16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 8'h05, 8'h2B, 1'b0, 9'd0,  9'd0, 16'h0000, 1'b0};
        vecs[10] = '{1'b0, 8'h2C, 8'h2C, 1'b0, 9'd0,  9'd0, 16'h0000, 1'b0};
        vecs[11] = '{1'b1, 8'hF8, 8'h2C, 1'b0, 9'd0,  9'd0, 16'h0000, 1'b0};
        vecs[12] = '{1'b1, 8'h00, 8'h2C, 1'b1, 9'd10, 9'd5, 16'hF800, 1'b0};
        vecs[13] = '{1'b1, 8'h07, 8'h2C, 1'b0, 9'd0,  9'd0, 16'h0000, 1'b0};
        vecs[14] = '{1'b1, 8'hE0, 8'h2C, 1'b1, 9'd11, 9'd5, 16'h07E0, 1'b0};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst o_byte", 40'(o_byte), 40'h0);
        check("rst o_cmd", 40'(o_cmd), 40'h0);
        check("rst valids", 40'({o_byte_valid, o_byte_dc, o_pix_valid, o_frame_done, o_err}), 40'h0);
        check("rst pix", 40'({o_pix_x, o_pix_y, o_pix_data}), 40'h0);
        rst_n = 1'b1;

        // table: window setup and first pixels, one byte at a time
        for (int i = 0; i < 15; i++) begin
            n = pix_q.size();
            send_byte(vecs[i].dc, vecs[i].data);
            gap();
            check($sformatf("vec%0d byte", i), 40'({last_dc, last_byte}), 40'({vecs[i].dc, vecs[i].data}));
            check($sformatf("vec%0d cmd", i), 40'(o_cmd), 40'(vecs[i].exp_cmd));
            if (vecs[i].pix) check_pix($sformatf("vec%0d pix", i), n, vecs[i].px, vecs[i].py, vecs[i].pd, vecs[i].fd);
            else check($sformatf("vec%0d no pix", i), 40'(pix_q.size()), 40'(n));
        end
        // third pixel closes the 3x1 window
        n = pix_q.size();
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h1F);
        gap();
        check_pix("win last pix", n, 9'd12, 9'd5, 16'h001F, 1'b1);
        check("err clean", 40'(o_err), 40'h0);

        // rejected windows: end = WIDTH, and start > end
        do_reset();
        send_window(8'h2A, 16'd240, 16'd240);
        gap();
        check("caset 240 err", 40'(o_err), 40'(ERR_ON));
        send_window(8'h2B, 16'd5, 16'd4);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hAB);
        send_byte(1'b1, 8'hCD);
        gap();
        check_pix("rejected win pix", 0, 9'd0, 9'd0, 16'hABCD, 1'b0);

        // CS high mid-byte, then mid-pixel
        do_reset();
        send_byte(1'b0, 8'h2C);
        send_bits(8'hA5, 4);
        check("abort err", 40'(o_err), 40'(ERR_ON));
        send_byte(1'b1, 8'h12);
        send_byte(1'b1, 8'h34);
        gap();
        check("abort pix count", 40'(pix_q.size()), 40'd1);
        check_pix("abort pix", 0, 9'd0, 9'd0, 16'h1234, 1'b0);
        send_byte(1'b1, 8'h56);
        send_bits(8'h9F, 3);
        send_byte(1'b1, 8'h78);
        send_byte(1'b1, 8'h9A);
        gap();
        check("half pix count", 40'(pix_q.size()), 40'd2);
        check_pix("half pix dropped", 1, 9'd1, 9'd0, 16'h789A, 1'b0);

        // CASET abandoned after 2 params keeps the previous window, no error
        do_reset();
        send_window(8'h2A, 16'd10, 16'd12);
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h03);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h12);
        send_byte(1'b1, 8'h34);
        gap();
        check_pix("abandon pix", 0, 9'd10, 9'd0, 16'h1234, 1'b0);
        check("abandon err", 40'(o_err), 40'h0);

        // panel-corner window 238..239 x 318..319, back-to-back pixels
        do_reset();
        send_window(8'h2A, 16'd238, 16'd239);
        send_window(8'h2B, 16'd318, 16'd319);
        send_byte(1'b0, 8'h2C);
        for (int k = 0; k < 5; k++) begin
            send_byte(1'b1, 8'hC0);
            send_byte(1'b1, 8'(k));
        end
        gap();
        check_pix("corner p0", 0, 9'd238, 9'd318, 16'hC000, 1'b0);
        check_pix("corner p1", 1, 9'd239, 9'd318, 16'hC001, 1'b0);
        check_pix("corner p2", 2, 9'd238, 9'd319, 16'hC002, 1'b0);
        check_pix("corner p3", 3, 9'd239, 9'd319, 16'hC003, 1'b1);
        check_pix("corner p4", 4, 9'd238, 9'd318, 16'hC004, 1'b0);
        check("corner fd count", 40'(fd_cnt), 40'd1);

        // default window: first row wraps at x=239
        do_reset();
        send_byte(1'b0, 8'h2C);
        for (int k = 0; k < 241; k++) begin
            send_byte(1'b1, 8'(k >> 8));
            send_byte(1'b1, 8'(k));
        end
        gap();
        check("row pix count", 40'(pix_q.size()), 40'd241);
        check_pix("row p0", 0, 9'd0, 9'd0, 16'd0, 1'b0);
        check_pix("row p239", 239, 9'd239, 9'd0, 16'd239, 1'b0);
        check_pix("row p240", 240, 9'd0, 9'd1, 16'd240, 1'b0);
        check("row fd count", 40'(fd_cnt), 40'd0);

        // reset in the middle of RAMWR
        do_reset();
        send_window(8'h2A, 16'd10, 16'd12);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h77);
        send_byte(1'b1, 8'h88);
        send_byte(1'b1, 8'h99);
        @(negedge clk);
        rst_n = 1'b0;
        cs    = 1'b1;
        #1;
        check("midrst cmd/byte", 40'({o_cmd, o_byte}), 40'h0);
        check("midrst pix", 40'({o_pix_valid, o_pix_x, o_pix_y, o_pix_data}), 40'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = pix_q.size();
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h12);
        send_byte(1'b1, 8'h34);
        gap();
        check("midrst byte", 40'({last_dc, last_byte}), 40'({1'b1, 8'h34}));
        check_pix("midrst pix", base, 9'd0, 9'd0, 16'h1234, 1'b0);
        check("midrst err", 40'(o_err), 40'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
